reg_access_arbiter: RTL and testbench
=====================================

// Module: reg_access_arbiter
// PURPOSE
//  Shares the single-register top datapath (wr/addr/din -> dout) between two requesters.
//  Arbitrates requests, sequences each access as a multi-cycle transaction on the register bus,
//  captures read data one cycle after the read strobe, and signals completion per requester.
//  Sits between the two requesters and the register block; the only driver of the block's wr/addr/din.
// PARAMETERS
//  DW  8  data width of register bus and requester write/read data
//  AW  1  address width; addr '1 (all ones) is the idle/no-op address
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  req        in   2      per-requester request, level; bit i = requester i
//  req_wr     in   2      per-requester command: 1=write, 0=read
//  req_addr0  in   AW     requester 0 address;  req_addr1 in AW: requester 1 address
//  req_wdata0 in   DW     requester 0 write data; req_wdata1 in DW: requester 1 write data
//  gnt        out  2      one-cycle pulse: command of requester i accepted (ISSUE cycle)
//  done       out  2      one-cycle pulse: transaction of requester i complete
//  rdata      out  DW     read data; valid with done on a read, held until next read capture
//  busy       out  1      1 whenever state != IDLE
//  reg_wr     out  1      to register block wr
//  reg_addr   out  AW     to register block addr
//  reg_din    out  DW     to register block din
//  reg_dout   in   DW     from register block dout
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE; gnt=0, done=0, busy=0, rdata=0; reg_wr=0, reg_addr='1,
//   reg_din=0; RR pointer last=1 (requester 0 wins first). Reset mid-transaction aborts it: no done.
//  Idle bus: reg_wr=0, reg_addr='1, reg_din=0 (addr 0 with wr=0 would copy tempin->tempout).
//  FSM: IDLE -> ISSUE -> (write) RESP -> IDLE; IDLE -> ISSUE -> (read) CAPT -> RESP -> IDLE.
//   IDLE: if |req at edge: pick winner, latch wr/addr/wdata of winner, go ISSUE; else stay.
//   ISSUE (1 cycle): gnt[w]=1; reg_wr=cmd_wr, reg_addr=cmd_addr, reg_din=cmd_wr?cmd_wdata:0.
//   CAPT (reads only): bus idle; rdata <= reg_dout at end of cycle.
//   RESP (1 cycle): done[w]=1, bus idle; next state IDLE (no arbitration in RESP).
//  Latency from IDLE edge sampling req (cycle N): gnt N+1; write done N+2; read done N+3.
//  Throughput: one transaction per 3 (write) / 4 (read) cycles incl. IDLE cycle.
//  Arbitration: round robin; both requesting -> grant !last; single requester -> granted; last<=w.
//  req is level: requester holds req and command stable until gnt, drops req by cycle after gnt
//   unless issuing another; req still high in an IDLE cycle starts a new transaction.
//  Requests sampled only in IDLE; req changes during ISSUE/CAPT/RESP ignored.
//  Any address is passed through; non-zero address is a no-op at the register block, reads of it
//   still return reg_dout captured in CAPT.
//  Write done does not modify rdata. gnt and done never asserted for both bits at once.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins a tie; RR pointer unused.
//  Not defined (default): round robin as above.
// TESTING
//  1 rst=1 two cycles -> gnt=0,done=0,busy=0,rdata=0,reg_wr=0,reg_addr='1,reg_din=0.
//  2 req0 write addr0 data 8'hA5 at N -> gnt[0] N+1 with reg_wr=1,reg_addr=0,reg_din=A5; done[0] N+2.
//  3 then req1 read addr0 -> reg_wr=0,reg_addr=0 at N+1; done[1] N+3 with rdata=8'hA5.
//  4 after reset req0 write 3C + req1 read same cycle -> req0 served first, req1 rdata=3C;
//    repeat both -> req1 first (RR); ARB_FIXED_PRIO_EN -> req0 first both times.
//  5 rst during CAPT of a read -> no done, all outputs at reset values next cycle; new read ok.
//  6 req1 read addr1 -> done[1] N+3, register contents unchanged (follow-up addr0 read verifies).

Source files
------------

// File: rtl/reg_access_arbiter.sv
// Two-requester arbiter and transaction sequencer for the single-register datapath bus.
// Optional macro ARB_FIXED_PRIO_EN: fixed priority (requester 0 wins ties) instead of round robin.
module reg_access_arbiter #(
  parameter int DW = 8,
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    req_wr,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          reg_wr,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_din,
  input  logic [DW-1:0] reg_dout,
  output logic [1:0]    dbg_state_o
);

  // Handshake: req[i] is a level held with its command until gnt[i] pulses in ISSUE;
  // done[i] pulses once in RESP. Requests are only looked at while IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          winner_q, winner_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pick;

`ifdef ARB_FIXED_PRIO_EN
  assign pick = req[0] ? 1'b0 : 1'b1;
`else
  logic last_q, last_d;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    last_d = last_q;
    if (req == 2'b11) pick = ~last_q;
    else              pick = req[1];
    if (state_q == S_IDLE && |req) last_d = pick;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      winner_q    <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '1;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    gnt         = 2'b00;
    done        = 2'b00;
    // Idle bus uses the all-ones address so the register block sees a true no-op.
    reg_wr      = 1'b0;
    reg_addr    = '1;
    reg_din     = '0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          winner_d    = pick;
          cmd_wr_d    = req_wr[pick];
          cmd_addr_d  = pick ? req_addr1 : req_addr0;
          cmd_wdata_d = pick ? req_wdata1 : req_wdata0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gnt[winner_q] = 1'b1;
        reg_wr        = cmd_wr_q;
        reg_addr      = cmd_addr_q;
        reg_din       = cmd_wr_q ? cmd_wdata_q : '0;
        state_d       = cmd_wr_q ? S_RESP : S_CAPT;
      end
      S_CAPT: begin
        rdata_d = reg_dout;
        state_d = S_RESP;
      end
      S_RESP: begin
        done[winner_q] = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata       = rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: register block model, vector table, arbitration and abort sequences.
module tb_reg_access_arbiter;
  localparam int DW = 8;
  localparam int AW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = '0;
  logic [1:0]    req_wr = '0;
  logic [AW-1:0] req_addr0 = '0;
  logic [AW-1:0] req_addr1 = '0;
  logic [DW-1:0] req_wdata0 = '0;
  logic [DW-1:0] req_wdata1 = '0;
  logic [1:0]    gnt, done, dbg_state;
  logic [DW-1:0] rdata, reg_din, reg_dout;
  logic          busy, reg_wr;
  logic [AW-1:0] reg_addr;

  int tests = 0;
  int fails = 0;
  logic [DW:0] exp_q[$];  // {requester, expected rdata at done}

  reg_access_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_din(reg_din),
    .reg_dout(reg_dout), .dbg_state_o(dbg_state)
  );

  // clock / register block model: only address 0 is storage
  always #5 clk = ~clk;

  logic [DW-1:0] reg_mem = '0;
  always @(posedge clk) if (reg_wr && reg_addr == '0) reg_mem <= reg_din;
  assign reg_dout = reg_mem;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: pop one expectation on every done pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt == 2'b11) check("gnt_onehot", 32'(gnt), 32'h0);
      if (done != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'h0);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("done_who", 32'(done), 32'(2'b01 << e[DW]));
          check("rdata", 32'(rdata), 32'(e[DW-1:0]));
        end
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called just after a posedge with the DUT idle; returns just after the posedge ending ISSUE.
  task automatic issue_txn(input bit who, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    int n;
    req_wr[who] = wr;
    if (who) begin req_addr1 = addr; req_wdata1 = wdata; end
    else     begin req_addr0 = addr; req_wdata0 = wdata; end
    req[who] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_reg_wr", 32'(reg_wr), 32'h0);
        check("idle_reg_addr", 32'(reg_addr), 32'(1'b1));
      end
    end while (gnt == 2'b00 && n < 6);
    check("gnt_latency", n, 2);
    check("gnt_who", 32'(gnt), 32'(2'b01 << who));
    check("issue_busy", 32'(busy), 32'h1);
    check("issue_reg_wr", 32'(reg_wr), 32'(wr));
    check("issue_reg_addr", 32'(reg_addr), 32'(addr));
    check("issue_reg_din", 32'(reg_din), wr ? 32'(wdata) : 32'h0);
    @(posedge clk);
    #1 req[who] = 1'b0;
  endtask

  task automatic finish_txn(input bit wr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 2'b00 && n < 6);
    check("done_latency", n, wr ? 1 : 2);
  endtask

  task automatic run_txn(input bit who, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
    exp_q.push_back({who, exp_rd});
    issue_txn(who, wr, addr, wdata);
    finish_txn(wr);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit            who;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit order[4];
    logic [DW-1:0] ord_rd[4];
    int g, cyc;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hA5};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h77, 8'hA5};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hA5};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hA5};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h5A, 8'hA5};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h5A};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 8'hC3, 8'h5A};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hC3};

    // reset values, checked while reset is still asserted
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_reg_wr", 32'(reg_wr), 32'h0);
    check("rst_reg_addr", 32'(reg_addr), 32'(1'b1));
    check("rst_reg_din", 32'(reg_din), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_txn(tbl[i].who, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
    end

    // simultaneous requests, both held until each has its expected grants
    reset_dut();
`ifdef ARB_FIXED_PRIO_EN
    order  = '{1'b0, 1'b0, 1'b0, 1'b1};
    ord_rd = '{8'h00, 8'h00, 8'h00, 8'h3C};
`else
    order  = '{1'b0, 1'b1, 1'b0, 1'b1};
    ord_rd = '{8'h00, 8'h3C, 8'h3C, 8'h3C};
`endif
    for (int k = 0; k < 4; k++) exp_q.push_back({order[k], ord_rd[k]});
    req_wr = 2'b01;
    req_addr0 = '0;
    req_wdata0 = 8'h3C;
    req_addr1 = '0;
    req = 2'b11;
    g = 0;
    cyc = 0;
    while (g < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (gnt != 2'b00) begin
        bit more0, more1;
        check("arb_gnt", 32'(gnt), 32'(2'b01 << order[g]));
        g++;
        more0 = 1'b0;
        more1 = 1'b0;
        for (int k = g; k < 4; k++) begin
          if (order[k]) more1 = 1'b1;
          else          more0 = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!more0) req[0] = 1'b0;
        if (!more1) req[1] = 1'b0;
      end
    end
    check("arb_grant_count", g, 4);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("arb_queue_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // reset during CAPT aborts the read without a done
    issue_txn(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_rdata", 32'(rdata), 32'h0);
    check("abort_reg_wr", 32'(reg_wr), 32'h0);
    check("abort_reg_addr", 32'(reg_addr), 32'(1'b1));
    check("abort_reg_din", 32'(reg_din), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'h0);
    end
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 1'b0, 8'h00, 8'h3C);

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
